// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and defaults for the data RAM responder
package ram_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_WAIT   = 2'd1,
        ST_WR_COMMIT = 2'd2,
        ST_RESP      = 2'd3
    } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port word array, synchronous write, registered read
module ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array contents survive reset; only the write strobe changes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds the last read word until the next read strobe.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read output register; cleared on reset so the response data starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - RAM request responder with read latency; LR/SC reservation under RAM_RESERVATION_EN
module data_ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W,
    parameter int READ_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iRAM_CE,
    input  logic              iRAM_RD,
    input  logic              iRAM_WR,
    input  logic [ADDR_W-1:0] iRAM_ADDR,
    input  logic [DATA_W-1:0] iRAM_DATA,
    input  logic              iRAM_LR,
    input  logic              iRAM_SC,
    output logic [DATA_W-1:0] oRAM_DATA,
    output logic              oRAM_READY,
    output logic              oRAM_VALID,
    output logic              oRAM_ERR,
    output logic              oRAM_SC_FAIL
);

    ram_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic              mem_re;

`ifdef RAM_RESERVATION_EN
    logic              lr_q, lr_d;
    logic              sc_q, sc_d;
    logic              sc_fail_q, sc_fail_d;
    logic              resv_valid_q, resv_valid_d;
    logic [ADDR_W-1:0] resv_addr_q, resv_addr_d;
    logic              resv_hit;

    assign resv_hit = resv_valid_q && (resv_addr_q == addr_q);
`else
    logic              unused_qual;

    assign unused_qual = iRAM_LR ^ iRAM_SC;
`endif

    // Next-state, request latching and array strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
`ifdef RAM_RESERVATION_EN
        lr_d         = lr_q;
        sc_d         = sc_q;
        sc_fail_d    = sc_fail_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iRAM_CE) begin
                    addr_d  = iRAM_ADDR;
                    wdata_d = iRAM_DATA;
                    err_d   = 1'b0;
`ifdef RAM_RESERVATION_EN
                    lr_d      = iRAM_LR;
                    sc_d      = iRAM_SC;
                    sc_fail_d = 1'b0;
`endif
                    if (iRAM_RD && !iRAM_WR) begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                    end else if (iRAM_WR && !iRAM_RD) begin
                        state_d = ST_WR_COMMIT;
                    end else begin
                        // Malformed op: respond immediately, array untouched.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    mem_re  = 1'b1;
                    state_d = ST_RESP;
`ifdef RAM_RESERVATION_EN
                    if (lr_q) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_COMMIT: begin
`ifdef RAM_RESERVATION_EN
                if (sc_q) begin
                    // Any SC consumes the reservation, pass or fail.
                    mem_we       = resv_hit;
                    sc_fail_d    = !resv_hit;
                    resv_valid_d = 1'b0;
                end else begin
                    mem_we = 1'b1;
                    if (resv_hit) begin
                        resv_valid_d = 1'b0;
                    end
                end
`else
                mem_we = 1'b1;
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any in-flight request.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef RAM_RESERVATION_EN
            lr_q         <= 1'b0;
            sc_q         <= 1'b0;
            sc_fail_q    <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef RAM_RESERVATION_EN
            lr_q         <= lr_d;
            sc_q         <= sc_d;
            sc_fail_q    <= sc_fail_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
`endif
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (iCLK),
        .rst_n (iRST),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (oRAM_DATA)
    );

    assign oRAM_READY = (state_q == ST_IDLE);
    assign oRAM_VALID = (state_q == ST_RESP);
    assign oRAM_ERR   = oRAM_VALID && err_q;
`ifdef RAM_RESERVATION_EN
    assign oRAM_SC_FAIL = oRAM_VALID && sc_fail_q;
`else
    assign oRAM_SC_FAIL = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - scoreboard bench for data_ram_responder
module tb_data_ram_responder;

    localparam int RL = 2;

    logic        clk;
    logic        rst_n;
    logic        ce, rd, wr, lr, sc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready, valid, err, sc_fail;

    data_ram_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(RL)) dut (
        .iCLK         (clk),
        .iRST         (rst_n),
        .iRAM_CE      (ce),
        .iRAM_RD      (rd),
        .iRAM_WR      (wr),
        .iRAM_ADDR    (addr),
        .iRAM_DATA    (wdata),
        .iRAM_LR      (lr),
        .iRAM_SC      (sc),
        .oRAM_DATA    (rdata),
        .oRAM_READY   (ready),
        .oRAM_VALID   (valid),
        .oRAM_ERR     (err),
        .oRAM_SC_FAIL (sc_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        bit          scf;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    // reference model state
    logic [31:0] mem_m [256];
    bit          known [256];
    logic [7:0]  known_list[$];
    logic [31:0] last_rd = 32'h0;
    bit          resv_v  = 1'b0;
    logic [7:0]  resv_a  = 8'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mark_known(input logic [7:0] a);
        if (!known[a]) begin
            known[a] = 1'b1;
            known_list.push_back(a);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got valid=1 want no response (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("valid_cycle", cyc, mon_e.cyc);
                    chk("err", {31'b0, err}, {31'b0, mon_e.err});
                    chk("sc_fail", {31'b0, sc_fail}, {31'b0, mon_e.scf});
                    chk("rdata", rdata, mon_e.data);
                    chk("ready_in_resp", {31'b0, ready}, 32'h0);
                end
            end else begin
                chk("quals_idle", {30'b0, err, sc_fail}, 32'h0);
            end
        end
    end

    task automatic idle(input int n);
        @(negedge clk);
        ce = 1'b0; rd = 1'b0; wr = 1'b0; lr = 1'b0; sc = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_req(input bit r, input bit w, input logic [7:0] a,
                          input logic [31:0] d, input bit l, input bit s);
        exp_t e;
        int   n = 0;
        int   lat;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 want 1 within 100 cycles");
            return;
        end
        ce = 1'b1; rd = r; wr = w; addr = a; wdata = d; lr = l; sc = s;
        e.err = (r == w);
        e.scf = 1'b0;
        if (e.err) begin
            lat = 0;
        end else if (r) begin
            lat = RL;
            last_rd = mem_m[a];
`ifdef RAM_RESERVATION_EN
            if (l) begin
                resv_v = 1'b1;
                resv_a = a;
            end
`endif
        end else begin
            lat = 1;
`ifdef RAM_RESERVATION_EN
            if (s) begin
                if (resv_v && resv_a == a) begin
                    mem_m[a] = d;
                    mark_known(a);
                end else begin
                    e.scf = 1'b1;
                end
                resv_v = 1'b0;
            end else begin
                mem_m[a] = d;
                mark_known(a);
                if (resv_v && resv_a == a) resv_v = 1'b0;
            end
`else
            mem_m[a] = d;
            mark_known(a);
`endif
        end
        e.data = last_rd;
        e.cyc  = cyc + 1 + lat;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        idle(0);
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'h0);
    endtask

    // Accept one request, then pull reset while it is still in flight.
    task automatic abort_req(input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_ready", {31'b0, ready}, 32'h1);
        ce = 1'b1; rd = r; wr = w; addr = a; wdata = d; lr = 1'b0; sc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_data", rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_scf", {31'b0, sc_fail}, 32'h0);
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
        last_rd = 32'h0;
        resv_v  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ce = 1'b0; rd = 1'b0; wr = 1'b0; lr = 1'b0; sc = 1'b0;
        addr = 8'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_data", rdata, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);
        chk("reset_scf", {31'b0, sc_fail}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'h1);

        // basic write then read
        do_req(0, 1, 8'h10, 32'hDEADBEEF, 0, 0);
        do_req(1, 0, 8'h10, 32'h0, 0, 0);
        idle(2);

        // malformed requests leave array and read data untouched
        do_req(0, 1, 8'h05, 32'h55555555, 0, 0);
        do_req(1, 0, 8'h05, 32'h0, 0, 0);
        do_req(1, 1, 8'h05, 32'h99999999, 0, 0);
        do_req(0, 0, 8'h05, 32'h88888888, 0, 0);
        do_req(1, 0, 8'h10, 32'h0, 0, 0);
        do_req(1, 0, 8'h05, 32'h0, 0, 0);
        idle(1);

        // CE held high across back-to-back requests
        for (int i = 0; i < 6; i++) begin
            do_req(0, 1, (i % 2 == 0) ? 8'h00 : 8'hFF, 32'hA0000000 + i, 0, 0);
        end
        do_req(1, 0, 8'h00, 32'h0, 0, 0);
        do_req(1, 0, 8'hFF, 32'h0, 0, 0);
        drain();

        // reset during a read wait and during a pending write
        do_req(0, 1, 8'h40, 32'h4040AAAA, 0, 0);
        do_req(1, 0, 8'h40, 32'h0, 0, 0);
        drain();
        abort_req(1, 0, 8'h40, 32'h0);
        abort_req(0, 1, 8'h40, 32'h4040BBBB);
        do_req(1, 0, 8'h40, 32'h0, 0, 0);
        drain();

        // LR/SC sequences (expectations follow the build)
        do_req(0, 1, 8'h20, 32'h00002020, 0, 0);
        do_req(1, 0, 8'h20, 32'h0, 1, 0);
        do_req(0, 1, 8'h20, 32'h00001234, 0, 1);
        do_req(0, 1, 8'h20, 32'h00005678, 0, 1);
        do_req(1, 0, 8'h20, 32'h0, 0, 0);
        do_req(0, 1, 8'h30, 32'h00003030, 0, 0);
        do_req(1, 0, 8'h30, 32'h0, 1, 0);
        do_req(0, 1, 8'h30, 32'h00003131, 0, 0);
        do_req(0, 1, 8'h30, 32'h00003232, 0, 1);
        do_req(1, 0, 8'h30, 32'h0, 0, 0);
        drain();

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [7:0]  a;
            logic [31:0] d;
            bit          l, s;
            kind = $urandom_range(0, 9);
            a    = ($urandom_range(0, 1) == 1) ? 8'(8'h20 + $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            d    = $urandom;
            l    = ($urandom_range(0, 2) == 0);
            s    = ($urandom_range(0, 2) == 0);
            if (kind == 0) begin
                bit both;
                both = ($urandom_range(0, 1) == 1);
                do_req(both, both, a, d, l, s);
            end else if (kind <= 4 && known_list.size() != 0) begin
                a = known_list[$urandom_range(0, known_list.size() - 1)];
                do_req(1, 0, a, 32'h0, l, 1'b0);
            end else begin
                do_req(0, 1, a, d, 1'b0, s);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
